// File: rtl/seven_seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_pkg
// Description : Shared segment decode table, blank pattern and scan states
//               for the multiplexed seven-segment driver.
// Revision    : 1.0 - initial release
// ============================================================================
package seven_seg_pkg;

    // Active-high gfedcba patterns for hex digits 0-F
    localparam logic [6:0] SEG_HEX_LUT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h67, 7'h77, 7'h7C, 7'h58, 7'h5E, 7'h79, 7'h71
    };

    localparam logic [6:0] SEG_ALL_OFF = 7'h7F;

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        ON    = 1'b1
    } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/seven_seg_mux_hex_to_seg.sv
`default_nettype none
// ============================================================================
// Module      : hex_to_seg
// Description : Combinational hex digit to active-low gfedcba segment decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module hex_to_seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = ~SEG_HEX_LUT[hex];

endmodule
`default_nettype wire

// File: rtl/seven_seg_mux.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_mux
// Description : Time-multiplexed N-digit common-anode seven-segment driver
//               with tear-free frame updates and anode dead-time blanking.
//               Optional leading-zero blanking: define SEVEN_SEG_LZ_BLANK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_mux
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 2,
    parameter int REFRESH_DIV = 24000,
    parameter int DEAD_CYCLES = 240
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    load,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic                    frame_done
);

    localparam int c_cnt_w = $clog2(REFRESH_DIV);
    localparam int c_idx_w = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(REFRESH_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_dead     = c_cnt_w'(DEAD_CYCLES);
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(NUM_DIGITS - 1);

    logic [4*NUM_DIGITS-1:0] r_capture_digits;
    logic [NUM_DIGITS-1:0]   r_capture_en;
    logic [4*NUM_DIGITS-1:0] r_shadow_digits;
    logic [NUM_DIGITS-1:0]   r_shadow_en;

    logic [c_cnt_w-1:0]      r_cnt;
    logic [c_idx_w-1:0]      r_idx;
    scan_state_t             r_state;

    logic [3:0]              w_digit_arr [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   w_show;
    logic [3:0]              w_cur_digit;
    logic                    w_cur_show;
    logic [6:0]              w_seg_dec;
    logic [NUM_DIGITS-1:0]   w_anode_on;

    // Capture on load; shadow only changes at the frame boundary so a scan
    // never mixes old and new digits.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_capture_digits <= '0;
            r_capture_en     <= '0;
            r_shadow_digits  <= '0;
            r_shadow_en      <= '0;
        end else begin
            if (load) begin
                r_capture_digits <= digits;
                r_capture_en     <= digit_en;
            end
            if (frame_done) begin
                r_shadow_digits <= load ? digits   : r_capture_digits;
                r_shadow_en     <= load ? digit_en : r_capture_en;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= '0;
            r_idx      <= '0;
            frame_done <= 1'b0;
        end else if (r_cnt == c_cnt_last) begin
            r_cnt      <= '0;
            r_idx      <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
            frame_done <= (r_idx == c_idx_last);
        end else begin
            r_cnt      <= r_cnt + 1'b1;
            frame_done <= 1'b0;
        end
    end

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_unpack
        assign w_digit_arr[gi] = r_shadow_digits[4*gi +: 4];
    end

`ifdef SEVEN_SEG_LZ_BLANK_EN
    // Walk from the most significant digit down; a digit is shown once any
    // digit at or above it is non-zero. Digit 0 always shows.
    logic w_nz_seen;
    always_comb begin
        w_nz_seen = 1'b0;
        w_show    = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_nz_seen = w_nz_seen | (w_digit_arr[i] != 4'h0);
            w_show[i] = r_shadow_en[i] & ((i == 0) | w_nz_seen);
        end
    end
`else
    assign w_show = r_shadow_en;
`endif

    assign w_cur_digit = w_digit_arr[r_idx];
    assign w_cur_show  = w_show[r_idx];
    assign w_anode_on  = ~(NUM_DIGITS'(1) << r_idx);

    hex_to_seg u_hex_to_seg (
        .hex (w_cur_digit),
        .seg (w_seg_dec)
    );

    // Outputs are registered from the previous counter value
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= BLANK;
            seg     <= SEG_ALL_OFF;
            anode   <= '1;
        end else begin
            case (r_state)
                BLANK: begin
                    if (r_cnt == c_dead) begin
                        r_state <= ON;
                        anode   <= w_anode_on;
                        seg     <= w_cur_show ? w_seg_dec : SEG_ALL_OFF;
                    end else begin
                        anode   <= '1;
                        seg     <= SEG_ALL_OFF;
                    end
                end
                ON: begin
                    if (r_cnt == '0) begin
                        r_state <= BLANK;
                        anode   <= '1;
                        seg     <= SEG_ALL_OFF;
                    end else begin
                        anode   <= w_anode_on;
                        seg     <= w_cur_show ? w_seg_dec : SEG_ALL_OFF;
                    end
                end
                default: begin
                    r_state <= BLANK;
                    anode   <= '1;
                    seg     <= SEG_ALL_OFF;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
